bitmask_mem_initiator: RTL and testbench

Request-side controller for `bit_masked_memory`. It accepts masked-write and read commands on a valid/ready request port and drives the memory's `enb`/`wr`/`addr`/`data`/`masked` pins. It captures `r_data` after a fixed read latency and returns results on a valid/ready response port. When verification is enabled, each masked write is followed by a readback compare, and mismatches are flagged.

---
 rtl/bitmask_mem_pkg.sv | 24 ++
 rtl/bitmask_mem_initiator.sv | 151 +++++++++++++++
 tb/tb_bitmask_mem_initiator.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bitmask_mem_pkg.sv
// Shared types for the bit-masked memory initiator.
//   state_e : controller FSM states
//   req_t   : one request-port command at the default widths
package bitmask_mem_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_WAIT = 3'd3,
    ST_RSP  = 3'd4
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_DATA_W-1:0] mask;
  } req_t;

endpackage

// File: rtl/bitmask_mem_initiator.sv
// Request-side controller for a bit-masked memory.
// Accepts masked-write / read commands, drives the memory pins, captures
// read data after READ_LAT cycles and returns a response. With VERIFY=1
// every write is followed by a readback that flags masked-bit mismatches.
//
// Ports
//   clk, rst                      : clock, async active-high reset
//   req_valid/req_ready           : command handshake
//   req_wr/req_addr/req_data/req_mask : command fields
//   rsp_valid/rsp_ready           : response handshake
//   rsp_data/rsp_err              : read word, verify mismatch
//   enb/wr/addr/data/masked       : memory control outputs
//   r_data                        : memory read data
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | ready for a command
// WR      | one-cycle masked write strobe
// RD      | one-cycle read issue (command read or readback)
// WAIT    | READ_LAT cycles until r_data is valid
// RSP     | response held until rsp_ready
module bitmask_mem_initiator
  import bitmask_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 1,
  parameter bit VERIFY   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [DATA_W-1:0] req_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              enb,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] masked,
  input  logic [DATA_W-1:0] r_data
);

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LAT - 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } cmd_t;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              req_ready_q, req_ready_d;
  logic              accept;

  assign accept = (state_q == ST_IDLE) && req_ready_q && req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    // Ready is registered: it is raised by the edge that leaves RSP (or any
    // idle edge) so a new command can be accepted on the following edge.
    req_ready_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d   = '{wr: req_wr, addr: req_addr, data: req_data, mask: req_mask};
          state_d = req_wr ? ST_WR : ST_RD;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_WR: begin
        if (VERIFY) begin
          state_d = ST_RD;
        end else begin
          state_d    = ST_RSP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      ST_RD: begin
        state_d = ST_WAIT;
        cnt_d   = LAT_M1;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = ST_RSP;
          rsp_data_d = r_data;
          // Only bits covered by the write mask are meaningful in a readback.
          rsp_err_d  = cmd_q.wr && (((r_data ^ cmd_q.data) & cmd_q.mask) != '0);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign enb       = (state_q == ST_WR) || (state_q == ST_RD);
  assign wr        = (state_q == ST_WR);
  assign addr      = cmd_q.addr;
  // Reads present a clean bus; elsewhere the latched write operands are held.
  assign data      = (state_q == ST_RD) ? '0 : cmd_q.data;
  assign masked    = (state_q == ST_RD) ? '0 : cmd_q.mask;

endmodule

// File: tb/tb_bitmask_mem_initiator.sv
module tb_bitmask_mem_initiator;
  import bitmask_mem_pkg::*;

  localparam int READ_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- verify build + behavioural memory ----------------
  logic        req_valid = 0, req_wr = 0, rsp_ready = 1;
  logic [2:0]  req_addr = '0;
  logic [31:0] req_data = '0, req_mask = '0;
  logic        req_ready, rsp_valid, rsp_err, enb, wr;
  logic [31:0] rsp_data, data, masked, r_data;
  logic [2:0]  addr;
  logic [31:0] mem [8];
  logic [31:0] mem_rd_q = '0;
  logic [31:0] r_flip = '0;
  logic [31:0] ref_mem [8];

  initial for (int i = 0; i < 8; i++) begin mem[i] = '0; ref_mem[i] = '0; end

  always @(posedge clk) begin
    if (enb) begin
      if (wr) mem[addr] <= (mem[addr] & ~masked) | (data & masked);
      else    mem_rd_q  <= mem[addr];
    end
  end
  assign r_data = mem_rd_q ^ r_flip;

  bitmask_mem_initiator #(.ADDR_W(3), .DATA_W(32), .READ_LAT(READ_LAT), .VERIFY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .enb(enb), .wr(wr), .addr(addr), .data(data), .masked(masked), .r_data(r_data)
  );

  // ---------------- write-only build ----------------
  logic        req_valid_nv = 0, req_wr_nv = 1, rsp_ready_nv = 1;
  logic [2:0]  req_addr_nv = '0;
  logic [31:0] req_data_nv = '0, req_mask_nv = '0;
  logic        req_ready_nv, rsp_valid_nv, rsp_err_nv, enb_nv, wr_nv;
  logic [31:0] rsp_data_nv, data_nv, masked_nv;
  logic [31:0] r_data_nv = '0;
  logic [2:0]  addr_nv;

  bitmask_mem_initiator #(.ADDR_W(3), .DATA_W(32), .READ_LAT(READ_LAT), .VERIFY(1'b0)) dut_nv (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_nv), .req_ready(req_ready_nv), .req_wr(req_wr_nv),
    .req_addr(req_addr_nv), .req_data(req_data_nv), .req_mask(req_mask_nv),
    .rsp_valid(rsp_valid_nv), .rsp_ready(rsp_ready_nv), .rsp_data(rsp_data_nv), .rsp_err(rsp_err_nv),
    .enb(enb_nv), .wr(wr_nv), .addr(addr_nv), .data(data_nv), .masked(masked_nv), .r_data(r_data_nv)
  );

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    chk("ready_timeout", req_ready, 1'b1);
  endtask

  // Issue one command, hold the response for 'hold' cycles, check everything.
  task automatic run_cmd(input req_t c, input int hold, input logic [31:0] flip_v);
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat, k, enb_cnt, wr_cnt, pin_bad;
    wait_ready();
    req_valid = 1; req_wr = c.wr; req_addr = c.addr; req_data = c.data; req_mask = c.mask;
    r_flip = flip_v; rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;

    if (c.wr) begin
      ref_mem[c.addr] = (ref_mem[c.addr] & ~c.mask) | (c.data & c.mask);
      exp_lat = READ_LAT + 2;
      exp_err = (flip_v & c.mask) != 0;
    end else begin
      exp_lat = READ_LAT + 1;
      exp_err = 1'b0;
    end
    exp_data = ref_mem[c.addr] ^ flip_v;

    k = 0; enb_cnt = 0; wr_cnt = 0; pin_bad = 0;
    while (!rsp_valid && k < 20) begin
      if (enb) begin
        enb_cnt++;
        if (addr != c.addr) pin_bad++;
        if (wr && (data != c.data || masked != c.mask)) pin_bad++;
        if (!wr && (data != 0 || masked != 0)) pin_bad++;
      end
      if (wr) wr_cnt++;
      @(negedge clk);
      k++;
    end
    chk("latency", k, exp_lat);
    chk("enb_cycles", enb_cnt, c.wr ? 2 : 1);
    chk("wr_cycles", wr_cnt, c.wr ? 1 : 0);
    chk("mem_pins", pin_bad, 0);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, exp_err);

    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_wr = 0; req_addr = c.addr + 3'd1;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_data", rsp_data, exp_data);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_ready", req_ready, 1'b0);
      chk("hold_enb", enb, 1'b0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    chk("post_hs_valid", rsp_valid, 1'b0);
    chk("post_hs_enb", enb, 1'b0);
    chk("post_hs_ready", req_ready, 1'b1);
    r_flip = '0;
  endtask

  req_t        q_nv [$];
  req_t        c, e;
  int          last, pulses, stray;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_enb", enb, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_masked", masked, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1'b1);

    // directed sequence
    run_cmd('{wr: 1'b1, addr: 3'd1, data: 32'hA5A5A5A5, mask: 32'h00FF00FF}, 0, '0);
    chk("dir_wr1_value", rsp_data, 32'h00A500A5);
    run_cmd('{wr: 1'b0, addr: 3'd1, data: 32'h0, mask: 32'h0}, 0, '0);
    run_cmd('{wr: 1'b1, addr: 3'd1, data: 32'h00FF00FF, mask: 32'hA5A5A5A5}, 0, '0);
    run_cmd('{wr: 1'b1, addr: 3'd2, data: 32'h12345678, mask: 32'h00000001}, 0, 32'h1);
    chk("dir_flip_err", rsp_err, 1'b1);
    run_cmd('{wr: 1'b1, addr: 3'd3, data: 32'hFFFFFFFF, mask: 32'h0}, 3, '0);
    run_cmd('{wr: 1'b1, addr: 3'd7, data: 32'hDEADBEEF, mask: 32'hFFFFFFFF}, 0, '0);

    // random traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      c.wr   = $urandom_range(0, 1);
      c.addr = 3'($urandom_range(0, 7));
      c.data = $urandom;
      c.mask = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      run_cmd(c, $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
    end

    // reset while waiting for read data
    wait_ready();
    req_valid = 1; req_wr = 0; req_addr = 3'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_enb", enb, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b0);
    chk("midrst_addr", addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("midrst_ready_back", req_ready, 1'b1);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || enb) stray++;
    end
    chk("midrst_no_stale", stray, 0);
    run_cmd('{wr: 1'b0, addr: 3'd7, data: 32'h0, mask: 32'h0}, 0, '0);

    // write-only build: back-to-back writes with rsp_ready high
    @(negedge clk);
    c.wr = 1; c.addr = 3'($urandom_range(0, 7)); c.data = $urandom; c.mask = $urandom;
    req_addr_nv = c.addr; req_data_nv = c.data; req_mask_nv = c.mask;
    q_nv.push_back(c);
    req_valid_nv = 1;
    last = -1; pulses = 0;
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      if (enb_nv && wr_nv) begin
        if (q_nv.size() > 0) begin
          e = q_nv.pop_front();
          chk("nv_addr", addr_nv, e.addr);
          chk("nv_data", data_nv, e.data);
          chk("nv_mask", masked_nv, e.mask);
        end else begin
          chk("nv_unexpected_write", 1'b1, 1'b0);
        end
        if (last >= 0) chk("nv_gap", k - last, 3);
        last = k;
        pulses++;
      end
      if (rsp_valid_nv) begin
        chk("nv_rsp_data", rsp_data_nv, 0);
        chk("nv_rsp_err", rsp_err_nv, 1'b0);
      end
      if (req_ready_nv) begin
        c.addr = 3'($urandom_range(0, 7)); c.data = $urandom; c.mask = $urandom;
        req_addr_nv = c.addr; req_data_nv = c.data; req_mask_nv = c.mask;
        q_nv.push_back(c);
      end
    end
    req_valid_nv = 0;
    chk("nv_pulses", pulses, 11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
